// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// The op encoding must stay in step with the decoder's MCycleOp output.
package mcycle_pkg;

    localparam int MC_WIDTH = 32;

    localparam logic MC_OP_MUL = 1'b0;
    localparam logic MC_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mcycle_unit.sv
// Unsigned shift-add multiplier / restoring divider, one step per cycle.
// MUL and DIV share a single WIDTH+1-bit adder and a 2*WIDTH+1-bit shift register.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MC_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mc_state_e          state;
    logic [CW-1:0]      count;
    logic               op;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_next;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH+1:0]   sum;
    logic               quot_bit;

    // DIV subtracts as a + ~b + 1; the carry out is set exactly when the difference is non-negative.
    always_comb begin
        shifted = {acc[2*WIDTH-1:0], 1'b0};
        if (op == MC_OP_DIV) begin
            add_a   = shifted[2*WIDTH:WIDTH];
            add_b   = ~{1'b0, operand};
            add_cin = 1'b1;
        end else begin
            add_a   = acc[2*WIDTH:WIDTH];
            add_b   = {1'b0, operand};
            add_cin = 1'b0;
        end
        sum      = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
        quot_bit = sum[WIDTH+1];

        if (op == MC_OP_DIV) begin
            acc_next = quot_bit ? {sum[WIDTH:0], shifted[WIDTH-1:1], 1'b1} : shifted;
        end else begin
            acc_next = acc[0] ? {1'b0, sum[WIDTH:0], acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};
        end
    end

    // The low half of acc starts with the multiplier (MUL) or the dividend (DIV).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            count   <= '0;
            op      <= MC_OP_MUL;
            operand <= '0;
            acc     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op      <= MCycleOp;
                        operand <= (MCycleOp == MC_OP_DIV) ? Operand2 : Operand1;
                        acc     <= {{(WIDTH+1){1'b0}},
                                    ((MCycleOp == MC_OP_DIV) ? Operand1 : Operand2)};
                        count   <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        Result1 <= acc_next[WIDTH-1:0];
                        Result2 <= acc_next[2*WIDTH-1:WIDTH];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy = ((state == IDLE) && Start && !RESET) || (state == COMPUTE);

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_mcycle_unit;

    localparam int WIDTH = 32;

    logic             CLK;
    logic             RESET;
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    int checks = 0;
    int errors = 0;

    mcycle_unit #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic: {high/remainder, low/quotient}.
    function automatic logic [63:0] modelResult(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op == 1'b0)
            return 64'(a) * 64'(b);
        else if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        else
            return {a % b, a / b};
    endfunction

    // Model: 0 = waiting, 1 = working (cycles_left to go), 2 = result cycle.
    int          m_phase = 0;
    int          m_left = 0;
    logic [63:0] m_pending = '0;
    logic [31:0] m_r1 = '0;
    logic [31:0] m_r2 = '0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_phase = 0;
            m_r1 = '0;
            m_r2 = '0;
        end else if (m_phase == 0) begin
            if (Start) begin
                m_pending = modelResult(MCycleOp, Operand1, Operand2);
                m_left = WIDTH;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_r1 = m_pending[31:0];
                m_r2 = m_pending[63:32];
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge CLK) begin
        checkOutput("model_busy", {63'd0, Busy},
                    {63'd0, (m_phase == 1) || (m_phase == 0 && Start && !RESET)});
        checkOutput("model_result1", {32'd0, Result1}, {32'd0, m_r1});
        checkOutput("model_result2", {32'd0, Result2}, {32'd0, m_r2});
    end

    // Issues one request, keeps Start high until Busy reads 0, checks the DONE-cycle results.
    task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_r1, input logic [31:0] exp_r2,
                                 input bit change_mid);
        int cycles;
        @(posedge CLK);
        #1;
        Start = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!Busy) break;
            cycles++;
            if (change_mid && cycles == 5) begin
                Operand1 = 32'd5;
                Operand2 = 32'd5;
                MCycleOp = ~op;
            end
        end
        checkOutput("busy_cycles", 64'(cycles), 64'd33);
        checkOutput("done_result1", {32'd0, Result1}, {32'd0, exp_r1});
        checkOutput("done_result2", {32'd0, Result2}, {32'd0, exp_r2});
    endtask

    task automatic goIdle(input int n);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (n) @(posedge CLK);
    endtask

    initial begin
        $display("[TB] mcycle_unit bench start");
        RESET = 1'b1;
        Start = 1'b1;
        MCycleOp = 1'b0;
        Operand1 = 32'd3;
        Operand2 = 32'd4;

        // Start held during reset must not raise Busy or begin an operation.
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
        checkOutput("reset_result1", {32'd0, Result1}, 64'd0);
        checkOutput("reset_result2", {32'd0, Result2}, 64'd0);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);

        applyStimulus(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
        goIdle(1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        goIdle(1);
        applyStimulus(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        goIdle(1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0);
        goIdle(1);

        // Abort at COMPUTE iteration 10 (cycle 11 after the request).
        @(posedge CLK);
        #1;
        Start = 1'b1;
        MCycleOp = 1'b0;
        Operand1 = 32'd12345;
        Operand2 = 32'd678;
        for (int i = 0; i < 12; i++) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        Start = 1'b0;
        @(negedge CLK);
        checkOutput("abort_busy", {63'd0, Busy}, 64'd0);
        checkOutput("abort_result1", {32'd0, Result1}, 64'd0);
        checkOutput("abort_result2", {32'd0, Result2}, 64'd0);

        applyStimulus(1'b1, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
        goIdle(1);

        // Operands and op change mid-COMPUTE; Start stays high through DONE, then a second request.
        applyStimulus(1'b1, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b1);
        applyStimulus(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0);
        goIdle(3);
        @(negedge CLK);
        checkOutput("hold_result1", {32'd0, Result1}, 64'd0);
        checkOutput("hold_result2", {32'd0, Result2}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
